tinytone_sequencer: RTL and testbench

TINYTONE_SEQUENCER -- requirements
Module: tinytone_sequencer

---
 rtl/tinytone_sequencer.sv | 171 +++++++++++++++++
 tb/tb_tinytone_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinytone_sequencer.sv
// tinytone_sequencer: multi-channel square-wave tone sequencer.
// Each channel owns a 2**AW-step pattern memory of tone periods (in clocks).
// Playback walks the steps at tempo_i clocks per step. Each channel emits a
// 50% square wave of the stored period. A popcount mix and a single-bit PWM
// mix of the channels are also provided.
// Build option: define TINYTONE_LOOP_EN to loop the pattern forever instead
// of stopping after the final step.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   start_i, stop_i        start/restart playback, abort playback (stop wins)
//   tempo_i, last_step_i   clocks per step, index of the final step
//   wr_en_i/ch/addr/data   pattern write port (channel >= NUM_CH ignored)
//   busy_o, strb_o, done_o playing, step-advance pulse, end-of-pattern pulse
//   step_o                 current step index
//   ch_o, mix_o, pwm_o     per-channel waves, count of high channels, PWM mix
module tinytone_sequencer #(
  parameter int unsigned BW     = 24,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned AW     = 4
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         start_i,
  input  logic                                         stop_i,
  input  logic [BW-1:0]                                tempo_i,
  input  logic [AW-1:0]                                last_step_i,
  input  logic                                         wr_en_i,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch_i,
  input  logic [AW-1:0]                                wr_addr_i,
  input  logic [BW-1:0]                                wr_data_i,
  output logic                                         busy_o,
  output logic                                         strb_o,
  output logic                                         done_o,
  output logic [AW-1:0]                                step_o,
  output logic [NUM_CH-1:0]                            ch_o,
  output logic [$clog2(NUM_CH+1)-1:0]                  mix_o,
  output logic                                         pwm_o
);

  localparam int unsigned CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned MW    = $clog2(NUM_CH + 1);
  localparam int unsigned DEPTH = 2 ** AW;

`ifdef TINYTONE_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic {IDLE, PLAY} state_t;

  state_t          state;
  logic [BW-1:0]   mem   [NUM_CH][DEPTH];
  logic [BW-1:0]   tcnt;
  logic [BW-1:0]   note  [NUM_CH];
  logic [BW-1:0]   phase [NUM_CH];
  logic [CW-1:0]   m;

  logic [BW-1:0]   tmax;
  logic            at_last;
  logic [AW-1:0]   adv_step;
  logic            restart;
  logic            advance;
  logic            go_play;
  logic            load;
  logic [AW-1:0]   load_addr;
  logic [AW-1:0]   step_n;
  logic [BW-1:0]   tcnt_n;
  logic            strb_n;
  logic            done_n;
  logic [BW-1:0]   note_n  [NUM_CH];
  logic [BW-1:0]   phase_n [NUM_CH];
  logic [NUM_CH-1:0] ch_n;
  logic [CW-1:0]   m_n;
  logic            pwm_n;

  function automatic logic [MW-1:0] popcnt(input logic [NUM_CH-1:0] v);
    logic [MW-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) s = s + MW'(v[i]);
    return s;
  endfunction

  // Pattern memory: not reset, writable in any state.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && (32'(wr_ch_i) < NUM_CH)) begin
      mem[wr_ch_i][wr_addr_i] <= wr_data_i;
    end
  end

  // Next-value datapath; strb/done/ch/pwm are precomputed so the outputs
  // are registered yet line up with the counters they describe.
  always_comb begin
    tmax      = (tempo_i == '0) ? '0 : tempo_i - BW'(1);
    at_last   = (step_o == last_step_i);
    adv_step  = at_last ? '0 : step_o + AW'(1);
    restart   = start_i && !stop_i;
    advance   = (state == PLAY) && strb_o;

    if (stop_i)              go_play = 1'b0;
    else if (restart)        go_play = 1'b1;
    else if (state == PLAY)  go_play = !(advance && at_last && !LOOP_EN);
    else                     go_play = 1'b0;

    step_n    = restart ? '0 : (advance ? adv_step : step_o);
    tcnt_n    = (restart || strb_o) ? '0 : tcnt + BW'(1);
    strb_n    = (tcnt_n >= tmax);
    done_n    = strb_n && (step_n == last_step_i);
    load      = restart || advance;
    load_addr = restart ? '0 : adv_step;

    ch_n = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      // Memory read precedes any same-edge write, so a colliding write
      // leaves the old value in the note register.
      note_n[c] = load ? mem[c][load_addr] : note[c];
      if (load || (note_n[c] <= BW'(1)))          phase_n[c] = '0;
      else if (phase[c] >= note_n[c] - BW'(1))    phase_n[c] = '0;
      else                                        phase_n[c] = phase[c] + BW'(1);
      ch_n[c] = (note_n[c] > BW'(1)) && (phase_n[c] < (note_n[c] >> 1));
    end

    m_n   = (32'(m) >= NUM_CH - 1) ? '0 : m + CW'(1);
    pwm_n = (32'(m_n) < 32'(popcnt(ch_n)));
  end

  // Control FSM and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      strb_o <= 1'b0;
      done_o <= 1'b0;
      step_o <= '0;
      tcnt   <= '0;
      ch_o   <= '0;
      pwm_o  <= 1'b0;
      m      <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        note[c]  <= '0;
        phase[c] <= '0;
      end
    end else begin
      m      <= m_n;
      busy_o <= go_play;
      state  <= go_play ? PLAY : IDLE;
      if (go_play) begin
        step_o <= step_n;
        tcnt   <= tcnt_n;
        strb_o <= strb_n;
        done_o <= done_n;
        ch_o   <= ch_n;
        pwm_o  <= pwm_n;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          note[c]  <= note_n[c];
          phase[c] <= phase_n[c];
        end
      end else begin
        tcnt   <= '0;
        strb_o <= 1'b0;
        done_o <= 1'b0;
        ch_o   <= '0;
        pwm_o  <= 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) phase[c] <= '0;
      end
    end
  end

  assign mix_o = popcnt(ch_o);

endmodule

// File: tb/tb_tinytone_sequencer.sv
// Directed testbench for tinytone_sequencer (NUM_CH=2 main instance, plus a
// NUM_CH=3 instance to exercise out-of-range channel writes).
// Status vector layout: {busy, strb, done, step[3:0], ch[1:0], mix[1:0], pwm}.
module tb_tinytone_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [23:0] tempo = 24'd0;
  logic [3:0]  last = 4'd0;
  logic        wr_en = 1'b0;
  logic [0:0]  wr_ch = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [23:0] wr_data = 24'd0;
  logic        busy, strb, done, pwm;
  logic [3:0]  step;
  logic [1:0]  ch;
  logic [1:0]  mix;

  logic        wr_en3 = 1'b0;
  logic [1:0]  wr_ch3 = 2'd0;
  logic        busy3, strb3, done3, pwm3;
  logic [3:0]  step3;
  logic [2:0]  ch3;
  logic [1:0]  mix3;

  logic [11:0] obs;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          mref    = 0;

  always #5 clk = ~clk;

  tinytone_sequencer #(.BW(24), .NUM_CH(2), .AW(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .tempo_i(tempo), .last_step_i(last),
    .wr_en_i(wr_en), .wr_ch_i(wr_ch), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .busy_o(busy), .strb_o(strb), .done_o(done), .step_o(step),
    .ch_o(ch), .mix_o(mix), .pwm_o(pwm)
  );

  tinytone_sequencer #(.BW(24), .NUM_CH(3), .AW(4)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .tempo_i(tempo), .last_step_i(last),
    .wr_en_i(wr_en3), .wr_ch_i(wr_ch3), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .busy_o(busy3), .strb_o(strb3), .done_o(done3), .step_o(step3),
    .ch_o(ch3), .mix_o(mix3), .pwm_o(pwm3)
  );

  assign obs = {busy, strb, done, step, ch, mix, pwm};

  // Reference for the free-running modulo-2 PWM counter.
  always @(posedge clk) begin
    if (rst) mref <= 0;
    else     mref <= (mref == 1) ? 0 : 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int c, input int a, input int d);
    wr_en = 1'b1; wr_ch = 1'(c); wr_addr = 4'(a); wr_data = 24'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wr3(input int c, input int a, input int d);
    wr_en3 = 1'b1; wr_ch3 = 2'(c); wr_addr = 4'(a); wr_data = 24'(d);
    tick();
    wr_en3 = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_tests++;
    if (obs !== 12'h000) begin
      n_fail++; $display("FAIL reset got=%h exp=%h", obs, 12'h000);
    end
  endtask

  // Period-8 tone, tempo 100, two steps: strobes at 99 and 199, done at 199.
  task automatic test_tone();
    logic [11:0] e;
    int ph;
    logic c0;
    wr(0, 0, 8); wr(0, 1, 8); wr(1, 0, 0); wr(1, 1, 0);
    tempo = 24'd100; last = 4'd1;
    pulse_start();
    for (int k = 0; k < 200; k++) begin
      ph = (k % 100) % 8;
      c0 = (ph < 4);
      e = {1'b1, (k % 100 == 99), (k == 199), 4'(k / 100), 1'b0, c0, 1'b0, c0,
           (mref < int'(c0))};
      n_tests++;
      if (obs !== e) begin
        n_fail++; $display("FAIL tone k=%0d got=%h exp=%h", k, obs, e);
      end
      tick();
    end
`ifdef TINYTONE_LOOP_EN
    e = {1'b1, 1'b0, 1'b0, 4'd0, 2'b01, 2'b01, (mref < 1)};
`else
    e = {1'b0, 1'b0, 1'b0, 4'd1, 2'b00, 2'b00, 1'b0};
`endif
    n_tests++;
    if (obs !== e) begin
      n_fail++; $display("FAIL tone_end got=%h exp=%h", obs, e);
    end
    pulse_stop();
  endtask

  // Steps {10,0,6}, tempo 50, last step 2.
  task automatic test_steps();
    logic [11:0] e;
    int s, p, n;
    logic c0;
    wr(0, 0, 10); wr(0, 1, 0); wr(0, 2, 6);
    wr(1, 0, 0); wr(1, 1, 0); wr(1, 2, 0);
    tempo = 24'd50; last = 4'd2;
    pulse_start();
    for (int k = 0; k < 150; k++) begin
      s = k / 50; p = k % 50;
      n = (s == 0) ? 10 : ((s == 1) ? 0 : 6);
      if (n > 1) c0 = ((p % n) < (n / 2));
      else       c0 = 1'b0;
      e = {1'b1, (p == 49), (k == 149), 4'(s), 1'b0, c0, 1'b0, c0, (mref < int'(c0))};
      n_tests++;
      if (obs !== e) begin
        n_fail++; $display("FAIL steps k=%0d got=%h exp=%h", k, obs, e);
      end
      tick();
    end
`ifdef TINYTONE_LOOP_EN
    e = {1'b1, 1'b0, 1'b0, 4'd0, 2'b01, 2'b01, (mref < 1)};
`else
    e = {1'b0, 1'b0, 1'b0, 4'd2, 2'b00, 2'b00, 1'b0};
`endif
    n_tests++;
    if (obs !== e) begin
      n_fail++; $display("FAIL steps_end got=%h exp=%h", obs, e);
    end
    pulse_stop();
  endtask

  // start_i during PLAY restarts at step 0 with a fresh tempo count.
  task automatic test_restart();
    logic [11:0] e;
    int s, p, n;
    logic c0;
    tempo = 24'd50; last = 4'd2;
    pulse_start();
    for (int k = 0; k < 60; k++) tick();
    pulse_start();
    for (int k = 0; k < 60; k++) begin
      s = k / 50; p = k % 50;
      n = (s == 0) ? 10 : 0;
      if (n > 1) c0 = ((p % n) < (n / 2));
      else       c0 = 1'b0;
      e = {1'b1, (p == 49), 1'b0, 4'(s), 1'b0, c0, 1'b0, c0, (mref < int'(c0))};
      n_tests++;
      if (obs !== e) begin
        n_fail++; $display("FAIL restart k=%0d got=%h exp=%h", k, obs, e);
      end
      tick();
    end
    pulse_stop();
  endtask

  // Reset mid-playback silences everything; memory survives.
  task automatic test_reset_mid();
    logic [11:0] e;
    int s, p, n;
    logic c0;
    pulse_start();
    for (int k = 0; k < 70; k++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_tests++;
    if (obs !== 12'h000) begin
      n_fail++; $display("FAIL reset_mid got=%h exp=%h", obs, 12'h000);
    end
    pulse_start();
    for (int k = 0; k < 60; k++) begin
      s = k / 50; p = k % 50;
      n = (s == 0) ? 10 : 0;
      if (n > 1) c0 = ((p % n) < (n / 2));
      else       c0 = 1'b0;
      e = {1'b1, (p == 49), 1'b0, 4'(s), 1'b0, c0, 1'b0, c0, (mref < int'(c0))};
      n_tests++;
      if (obs !== e) begin
        n_fail++; $display("FAIL replay k=%0d got=%h exp=%h", k, obs, e);
      end
      tick();
    end
    pulse_stop();
  endtask

  // Write to the address being loaded: old value is played, new is stored.
  task automatic test_write_collision();
    int ph;
    logic c0;
    wr(0, 0, 8); wr(0, 1, 8); wr(1, 0, 0); wr(1, 1, 0);
    tempo = 24'd20; last = 4'd1;
    pulse_start();
    for (int k = 0; k < 24; k++) begin
      ph = (k < 20) ? (k % 8) : (k - 20);
      c0 = (ph < 4);
      n_tests++;
      if (ch !== {1'b0, c0}) begin
        n_fail++; $display("FAIL collide k=%0d got=%b exp=%b", k, ch, {1'b0, c0});
      end
      if (k == 19) begin
        wr_en = 1'b1; wr_ch = 1'b0; wr_addr = 4'd1; wr_data = 24'd0;
      end
      tick();
      wr_en = 1'b0;
    end
    pulse_stop();
    pulse_start();
    for (int k = 0; k < 24; k++) begin
      c0 = (k < 20) && ((k % 8) < 4);
      n_tests++;
      if (ch !== {1'b0, c0}) begin
        n_fail++; $display("FAIL collide_new k=%0d got=%b exp=%b", k, ch, {1'b0, c0});
      end
      tick();
    end
    pulse_stop();
  endtask

  // Two in-phase period-4 channels, then channel 1 resting.
  task automatic test_mix();
    logic [11:0] e;
    logic c;
    wr(0, 0, 4); wr(1, 0, 4);
    tempo = 24'd200; last = 4'd0;
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      c = ((k % 4) < 2);
      e = {1'b1, 1'b0, 1'b0, 4'd0, c, c, c, 1'b0, c};
      n_tests++;
      if (obs !== e) begin
        n_fail++; $display("FAIL mix2 k=%0d got=%h exp=%h", k, obs, e);
      end
      tick();
    end
    pulse_stop();
    wr(1, 0, 0);
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      c = ((k % 4) < 2);
      e = {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, c, 1'b0, c, (mref < int'(c))};
      n_tests++;
      if (obs !== e) begin
        n_fail++; $display("FAIL mix1 k=%0d got=%h exp=%h", k, obs, e);
      end
      tick();
    end
  endtask

  // Simultaneous start and stop while playing: stop wins.
  task automatic test_stop_start();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obs !== 12'h000) begin
        n_fail++; $display("FAIL stop_start k=%0d got=%h exp=%h", k, obs, 12'h000);
      end
      tick();
    end
  endtask

  // tempo_i = 0 behaves as 1: a strobe every playing cycle.
  task automatic test_tempo0();
    logic [11:0] e;
    for (int a = 0; a < 4; a++) begin
      wr(0, a, 8); wr(1, a, 0);
    end
    tempo = 24'd0; last = 4'd3;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      e = {1'b1, 1'b1, (k == 3), 4'(k), 2'b01, 2'b01, (mref < 1)};
      n_tests++;
      if (obs !== e) begin
        n_fail++; $display("FAIL tempo0 k=%0d got=%h exp=%h", k, obs, e);
      end
      tick();
    end
`ifdef TINYTONE_LOOP_EN
    e = {1'b1, 1'b1, 1'b0, 4'd0, 2'b01, 2'b01, (mref < 1)};
`else
    e = {1'b0, 1'b0, 1'b0, 4'd3, 2'b00, 2'b00, 1'b0};
`endif
    n_tests++;
    if (obs !== e) begin
      n_fail++; $display("FAIL tempo0_end got=%h exp=%h", obs, e);
    end
    pulse_stop();
  endtask

  // Channel index beyond NUM_CH is ignored (NUM_CH=3 instance, channel 3).
  task automatic test_wr_ignore();
    logic [2:0] ec;
    wr3(0, 0, 0); wr3(1, 0, 0); wr3(2, 0, 8);
    wr3(3, 0, 4);
    tempo = 24'd100; last = 4'd0;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      ec = (k < 4) ? 3'b100 : 3'b000;
      n_tests++;
      if (ch3 !== ec || mix3 !== 2'(ec[2])) begin
        n_fail++; $display("FAIL wr_ignore k=%0d got=%b/%0d exp=%b/%0d", k, ch3, mix3, ec, ec[2]);
      end
      tick();
    end
    pulse_stop();
  endtask

  initial begin
    test_reset();
    test_tone();
    test_steps();
    test_restart();
    test_reset_mid();
    test_write_collision();
    test_mix();
    test_stop_start();
    test_tempo0();
    test_wr_ignore();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
